// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: op and state
// encodings, data width and the two's-complement magnitude helper.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the CPU pipeline and the HI/LO sequencer.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// One shift-add slice: partial product of mcand by a STEP_BITS multiplier
// digit, aligned to its digit position and added to the 64-bit accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int STEP_BITS = 1
) (
    input  logic [2*XLEN-1:0]  acc_i,
    input  logic [XLEN-1:0]    mcand_i,
    input  logic [STEP_BITS-1:0] digit_i,
    input  logic [5:0]         count_i,
    output logic [2*XLEN-1:0]  sum_o
);

    logic [2*XLEN-1:0] pp;
    logic [5:0]        shamt;

    // NOTE: pp gets a value before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (digit_i[i]) begin
                pp = pp + ({{XLEN{1'b0}}, mcand_i} << i);
            end
        end
    end

    assign shamt = 6'(count_i * STEP_BITS);
    assign sum_o = acc_i + (pp << shamt);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU sequencer owning HI/LO; MTHI/MTLO write in one cycle.
// busy holds off dependent HI/LO traffic until the product lands.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int STEP_BITS = 1
) (
    input logic         clk,
    input logic         reset,
    muldiv_seq_if.slave bus
);

    localparam int         ITERS = XLEN / STEP_BITS;
    localparam logic [5:0] LAST  = 6'(ITERS - 1);

    logic [1:0]        state_q,  state_d;
    logic [XLEN-1:0]   mcand_q,  mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [5:0]        count_q,  count_d;
    logic              neg_q,    neg_d;
    logic [XLEN-1:0]   hi_q,     hi_d;
    logic [XLEN-1:0]   lo_q,     lo_d;
    logic              done_q,   done_d;
    logic [2*XLEN-1:0] step_sum;

    muldiv_step #(.STEP_BITS(STEP_BITS)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[STEP_BITS-1:0]),
        .count_i (count_q),
        .sum_o   (step_sum)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A squash in the same cycle drops the request, MTHI/MTLO included.
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULTU, OP_MULT: begin
                            if (bus.op == OP_MULT) begin
                                mcand_d  = abs_val(bus.a);
                                mplier_d = abs_val(bus.b);
                                neg_d    = bus.a[XLEN-1] ^ bus.b[XLEN-1];
                            end else begin
                                mcand_d  = bus.a;
                                mplier_d = bus.b;
                                neg_d    = 1'b0;
                            end
                            acc_d   = '0;
                            count_d = '0;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = bus.a;
                        default: lo_d = bus.a;
                    endcase
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = step_sum;
                    mplier_d = mplier_q >> STEP_BITS;
                    count_d  = count_q + 6'd1;
                    if (count_q == LAST) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    {hi_d, lo_d} = neg_q ? (~acc_q + 64'd1) : acc_q;
                    done_d       = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed checks of muldiv_seq at STEP_BITS=1 (dut1) and STEP_BITS=4 (dut4).
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset1 = 1'b0;
    logic reset4 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq_if bus1 ();
    muldiv_seq_if bus4 ();

    muldiv_seq #(.STEP_BITS(1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));
    muldiv_seq #(.STEP_BITS(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic st, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
        if (w) begin
            bus4.start = st; bus4.op = op; bus4.a = a; bus4.b = b; bus4.flush = fl;
        end else begin
            bus1.start = st; bus1.op = op; bus1.a = a; bus1.b = b; bus1.flush = fl;
        end
    endtask

    function automatic logic get_done(input bit w);
        return w ? bus4.done : bus1.done;
    endfunction

    function automatic logic get_busy(input bit w);
        return w ? bus4.busy : bus1.busy;
    endfunction

    function automatic logic [63:0] get_hilo(input bit w);
        return w ? {bus4.hi, bus4.lo} : {bus1.hi, bus1.lo};
    endfunction

    // One-cycle request; operands are scrambled afterwards so a late latch would show.
    task automatic issue(input bit w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(w, 1'b1, op, a, b, 1'b0);
        tick();
        drive(w, 1'b0, OP_MULTU, 32'h5A5A_A5A5, 32'hC3C3_3C3C, 1'b0);
    endtask

    task automatic wait_done(input bit w, output int edges, output int busy_cnt);
        edges = 0;
        busy_cnt = 0;
        while (!get_done(w) && edges < 200) begin
            if (get_busy(w)) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    task automatic mul_case(input bit w, input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int edges, busy_cnt;
        issue(w, op, a, b);
        wait_done(w, edges, busy_cnt);
        check({tag, "_hilo"}, get_hilo(w), exp);
        check({tag, "_edges"}, 64'(edges), w ? 64'd9 : 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), w ? 64'd9 : 64'd33);
        check({tag, "_busy_at_done"}, 64'(get_busy(w)), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(get_done(w)), 64'd0);
    endtask

    initial begin
        int edges, busy_cnt, done_seen;
        drive(1'b0, 1'b0, OP_MULTU, '0, '0, 1'b0);
        drive(1'b1, 1'b0, OP_MULTU, '0, '0, 1'b0);
        #22;
        check("rst_hilo", get_hilo(1'b0), 64'd0);
        check("rst_busy", 64'(bus1.busy), 64'd0);
        check("rst_done", 64'(bus1.done), 64'd0);
        reset1 = 1'b1;
        reset4 = 1'b1;
        tick();

        mul_case(1'b0, "multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        mul_case(1'b0, "mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
        mul_case(1'b0, "mult_min_x_m1", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        mul_case(1'b0, "mult_max_x_min", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        // MTHI then MTLO back to back from IDLE
        drive(1'b0, 1'b1, OP_MTHI, 32'h1234_5678, '0, 1'b0);
        tick();
        check("mthi_hi", 64'(bus1.hi), 64'h1234_5678);
        check("mthi_busy_done", {62'd0, bus1.busy, bus1.done}, 64'd0);
        drive(1'b0, 1'b1, OP_MTLO, 32'h9ABC_DEF0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b0, OP_MULTU, '0, '0, 1'b0);
        check("mtlo_hilo", get_hilo(1'b0), 64'h1234_5678_9ABC_DEF0);
        check("mtlo_busy_done", {62'd0, bus1.busy, bus1.done}, 64'd0);

        // Flush on RUN cycle 10
        drive(1'b0, 1'b1, OP_MTHI, 32'h1111_1111, '0, 1'b0);
        tick();
        drive(1'b0, 1'b1, OP_MTLO, 32'h2222_2222, '0, 1'b0);
        tick();
        issue(1'b0, OP_MULTU, 32'd7, 32'd6);
        repeat (9) tick();
        check("flush_busy_before", 64'(bus1.busy), 64'd1);
        bus1.flush = 1'b1;
        tick();
        bus1.flush = 1'b0;
        check("flush_busy_after", 64'(bus1.busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus1.done) done_seen++;
            tick();
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_hilo_kept", get_hilo(1'b0), 64'h1111_1111_2222_2222);
        mul_case(1'b0, "multu_7x6", OP_MULTU, 32'd7, 32'd6, 64'd42);

        // Flush together with start in IDLE drops the op
        drive(1'b0, 1'b1, OP_MTHI, 32'hAAAA_AAAA, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, OP_MULTU, '0, '0, 1'b0);
        check("flush_start_idle", get_hilo(1'b0), 64'd42);
        check("flush_start_busy", 64'(bus1.busy), 64'd0);

        // MTLO issued while busy is ignored
        issue(1'b0, OP_MULT, 32'hFFFF_FFFF, 32'd100);
        repeat (3) tick();
        drive(1'b0, 1'b1, OP_MTLO, 32'hDEAD_BEEF, '0, 1'b0);
        tick();
        drive(1'b0, 1'b0, OP_MULTU, '0, '0, 1'b0);
        check("ignored_lo_mid", 64'(bus1.lo), 64'd42);
        wait_done(1'b0, edges, busy_cnt);
        check("ignored_hilo", get_hilo(1'b0), 64'hFFFF_FFFF_FFFF_FF9C);
        tick();

        // Asynchronous reset mid-multiply, away from any clock edge
        issue(1'b0, OP_MULTU, 32'd7, 32'd6);
        repeat (4) tick();
        check("prerst_busy", 64'(bus1.busy), 64'd1);
        #2;
        reset1 = 1'b0;
        #1;
        check("async_rst_hilo", get_hilo(1'b0), 64'd0);
        check("async_rst_busy", 64'(bus1.busy), 64'd0);
        check("async_rst_done", 64'(bus1.done), 64'd0);
        #1;
        reset1 = 1'b1;
        tick();

        // STEP_BITS = 4
        mul_case(1'b1, "s4_multu", OP_MULTU, 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF);
        mul_case(1'b1, "s4_mult", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
        mul_case(1'b1, "s4_multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply sequencer for the 54-instruction CPU. Owns the architectural HI/LO registers.
- Executes MULT/MULTU as an iterative shift-add over STEP_BITS multiplier bits per cycle, and MTHI/MTLO as single-cycle writes.
- Drives `busy` so the decode/stall logic holds MFHI/MFLO and further HI/LO ops until the product is written.

Parameters:
- STEP_BITS, 1, multiplier bits consumed per RUN cycle; legal values 1, 2, 4; iterations N = 32/STEP_BITS

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low
- start  input  1  op request, sampled at rising edge
- op  input  2  00 MULTU, 01 MULT, 10 MTHI, 11 MTLO
- a  input  32  rs operand (multiplicand, or MTHI/MTLO data)
- b  input  32  rt operand (multiplier)
- flush  input  1  cancel in-flight multiply (exception/branch squash)
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse, high in the cycle HI/LO first show a new product
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: while `reset` is low, state=IDLE, hi=0, lo=0, busy=0, done=0, internal accumulator/counter=0. Reset takes effect asynchronously at any time, including mid-multiply.
- States: IDLE, RUN, FIN. `busy` = (state != IDLE), decoded combinationally from the state register.
- IDLE, `start` with op MULTU/MULT:
  - latch mcand and mplier; clear the 64-bit accumulator and the iteration counter; enter RUN.
  - MULTU: operands are taken as-is.
  - MULT: latch |a| and |b| as 32-bit unsigned (|0x80000000| = 0x80000000) and latch neg = a[31]^b[31].
- IDLE, `start` with MTHI/MTLO:
  - hi<=a or lo<=a at that edge; state stays IDLE.
  - busy and done stay 0.
- RUN, each cycle:
  - acc += (mcand × mplier[STEP_BITS-1:0]) << (count×STEP_BITS);
  - mplier >>= STEP_BITS; count++.
  - After N iterations, go to FIN.
  - All sums are 64-bit unsigned; no overflow is possible.
- FIN, on the edge leaving FIN:
  - {hi,lo} <= neg ? (~acc + 1) : acc. neg is always 0 for MULTU.
  - Go to IDLE; done<=1 for exactly the next cycle.
- Latency: start sampled at edge 0 → RUN on edges 1..N → HI/LO valid and done=1 after edge N+1. busy is high for N+1 cycles (33 cycles when STEP_BITS=1).
- A new start is accepted in the same cycle that done=1.
- `start` while busy: ignored entirely; no latch and no HI/LO write. Stall logic is responsible for not issuing it.
- `flush` while busy: next edge returns to IDLE. HI/LO keep their pre-op values and done is not pulsed.
- `flush` in IDLE together with `start`: flush wins and the op (including MTHI/MTLO) is dropped.
- `flush` in IDLE alone: no effect.
- Operands `a`/`b` may change after the start edge without affecting the result.
- Undefined op encodings: none, all four are defined.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding constants (OP_MULTU, OP_MULT, OP_MTHI, OP_MTLO);
  - state encoding (S_IDLE, S_RUN, S_FIN);
  - the constant XLEN=32.
- One sub-module, muldiv_step: combinational partial-product generator plus 64-bit adder for one STEP_BITS slice.
  - Parameterised by STEP_BITS.
  - Reusable when DIV/DIVU sequencing is added next.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, STEP_BITS=1 → busy high 33 cycles; done after edge 33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=0x00000005 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT a=0x80000000 b=0xFFFFFFFF → hi=0x00000000, lo=0x80000000.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles in IDLE → hi/lo update at each edge; busy=0 and done=0 throughout.
- Flush case:
  - Preload hi=0x11111111 and lo=0x22222222 via MTHI/MTLO.
  - Start MULTU 7×6, then assert flush on RUN cycle 10 → busy drops after that edge, hi/lo unchanged, no done.
  - Immediate MULTU 7×6 → lo=42, hi=0.
- Ignored ops and reset:
  - During a MULT, issue start with MTLO a=0xDEADBEEF → ignored; final lo is the product.
  - Start another multiply and drive reset low at RUN cycle 5 → hi=lo=0, busy=0 without waiting for a clock edge.
- STEP_BITS=4, MULTU 0x0000FFFF × 0x00010001 → lo=0xFFFFFFFF, hi=0; done after edge 9.
